// File: rtl/kamacore_memory_stage.sv
// Memory-access stage: turns execute bundles into aligned dmem requests and formatted load results.
// Optional macro KAMACORE_MISALIGN_TRAP_EN completes misaligned half/word accesses as one-cycle traps.
module kamacore_memory_stage #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [CPU_WIDTH-1:0]      in_alu_result,
  input  logic [CPU_WIDTH-1:0]      in_rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] in_destination_register,
  input  logic                      in_control_memory_read,
  input  logic                      in_control_memory_write,
  input  logic                      in_control_write_register,
  input  logic [1:0]                in_mem_size,
  input  logic                      in_mem_unsigned,
  output logic                      stall_out,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [CPU_WIDTH-1:0]      dmem_addr,
  output logic [CPU_WIDTH-1:0]      dmem_wdata,
  output logic [3:0]                dmem_wstrb,
  input  logic [CPU_WIDTH-1:0]      dmem_rdata,
  input  logic                      dmem_ack,
  output logic                      out_valid,
  output logic [REG_ADDR_WIDTH-1:0] out_destination_register,
  output logic                      out_control_write_register,
  output logic [CPU_WIDTH-1:0]      out_alu_result,
  output logic [CPU_WIDTH-1:0]      out_data_memory_result,
  output logic                      out_misaligned
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]                state;
  logic                      is_mem;
  logic                      trap;
  logic [1:0]                lane;
  logic [CPU_WIDTH-1:0]      store_wdata;
  logic [3:0]                store_wstrb;
  logic [CPU_WIDTH-1:0]      load_data;
  logic [7:0]                load_byte;
  logic [15:0]               load_half;

  // Fields of the outstanding access, kept until the ack arrives
  logic [1:0]                acc_lane;
  logic [1:0]                acc_size;
  logic                      acc_unsigned;
  logic                      acc_store;
  logic [REG_ADDR_WIDTH-1:0] acc_rd;
  logic                      acc_write_register;
  logic [CPU_WIDTH-1:0]      acc_alu_result;

  assign is_mem    = in_control_memory_read | in_control_memory_write;
  assign lane      = in_alu_result[1:0];
  assign stall_out = (state == ACCESS);

`ifdef KAMACORE_MISALIGN_TRAP_EN
  logic misaligned_access;
  logic misaligned_q;

  assign misaligned_access = ((in_mem_size == 2'b01) && in_alu_result[0]) ||
                             (in_mem_size[1] && (lane != 2'b00));
  assign trap              = is_mem & misaligned_access;
  assign out_misaligned    = misaligned_q;

  // The flag rides with out_valid: set only by a trap completion, cleared by any other one
  always_ff @(posedge clk) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      misaligned_q <= trap;
    end else if ((state == ACCESS) && dmem_ack) begin
      misaligned_q <= 1'b0;
    end
  end
`else
  assign trap           = 1'b0;
  assign out_misaligned = 1'b0;
`endif

  always_comb begin
    store_wdata = in_rs2_data;
    store_wstrb = 4'b1111;
    case (in_mem_size)
      2'b00: begin
        store_wdata = {4{in_rs2_data[7:0]}};
        store_wstrb = 4'b0001 << lane;
      end
      2'b01: begin
        store_wdata = {2{in_rs2_data[15:0]}};
        store_wstrb = 4'b0011 << {in_alu_result[1], 1'b0};
      end
      default: begin
        store_wdata = in_rs2_data;
        store_wstrb = 4'b1111;
      end
    endcase
  end

  // Halves only look at addr[1]; a set addr[0] is ignored when not trapping
  always_comb begin
    load_byte = dmem_rdata[{acc_lane, 3'b000} +: 8];
    load_half = dmem_rdata[{acc_lane[1], 4'b0000} +: 16];
    case (acc_size)
      2'b00:   load_data = acc_unsigned ? {{(CPU_WIDTH-8){1'b0}}, load_byte}
                                        : {{(CPU_WIDTH-8){load_byte[7]}}, load_byte};
      2'b01:   load_data = acc_unsigned ? {{(CPU_WIDTH-16){1'b0}}, load_half}
                                        : {{(CPU_WIDTH-16){load_half[15]}}, load_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      dmem_req                   <= 1'b0;
      dmem_we                    <= 1'b0;
      dmem_addr                  <= '0;
      dmem_wdata                 <= '0;
      dmem_wstrb                 <= 4'b0000;
      out_valid                  <= 1'b0;
      out_destination_register   <= '0;
      out_control_write_register <= 1'b0;
      out_alu_result             <= '0;
      out_data_memory_result     <= '0;
      acc_lane                   <= 2'b00;
      acc_size                   <= 2'b00;
      acc_unsigned               <= 1'b0;
      acc_store                  <= 1'b0;
      acc_rd                     <= '0;
      acc_write_register         <= 1'b0;
      acc_alu_result             <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem || trap) begin
              out_valid                  <= 1'b1;
              out_destination_register   <= in_destination_register;
              out_control_write_register <= in_control_write_register & ~trap;
              out_alu_result             <= in_alu_result;
              out_data_memory_result     <= '0;
            end else begin
              // Write wins when both read and write are flagged
              state              <= ACCESS;
              dmem_req           <= 1'b1;
              dmem_we            <= in_control_memory_write;
              dmem_addr          <= {in_alu_result[CPU_WIDTH-1:2], 2'b00};
              dmem_wdata         <= in_control_memory_write ? store_wdata : '0;
              dmem_wstrb         <= in_control_memory_write ? store_wstrb : 4'b0000;
              acc_lane           <= lane;
              acc_size           <= in_mem_size;
              acc_unsigned       <= in_mem_unsigned;
              acc_store          <= in_control_memory_write;
              acc_rd             <= in_destination_register;
              acc_write_register <= in_control_write_register;
              acc_alu_result     <= in_alu_result;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state                      <= IDLE;
            dmem_req                   <= 1'b0;
            out_valid                  <= 1'b1;
            out_destination_register   <= acc_rd;
            out_control_write_register <= acc_write_register;
            out_alu_result             <= acc_alu_result;
            out_data_memory_result     <= acc_store ? '0 : load_data;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kamacore_memory_stage.sv
// Randomized bench for kamacore_memory_stage with a behavioural model and a reactive memory responder.
module tb_kamacore_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_destination_register;
  logic        in_control_memory_read;
  logic        in_control_memory_write;
  logic        in_control_write_register;
  logic [1:0]  in_mem_size;
  logic        in_mem_unsigned;
  logic        stall_out;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        out_valid;
  logic [4:0]  out_destination_register;
  logic        out_control_write_register;
  logic [31:0] out_alu_result;
  logic [31:0] out_data_memory_result;
  logic        out_misaligned;

  kamacore_memory_stage #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_destination_register(in_destination_register),
    .in_control_memory_read(in_control_memory_read),
    .in_control_memory_write(in_control_memory_write),
    .in_control_write_register(in_control_write_register),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid),
    .out_destination_register(out_destination_register),
    .out_control_write_register(out_control_write_register),
    .out_alu_result(out_alu_result),
    .out_data_memory_result(out_data_memory_result),
    .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

`ifdef KAMACORE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit check_en = 1'b0;

  // Responder controls
  int          fixed_delay = -1;
  bit          use_fixed_rdata = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  bit          spurious_en = 1'b0;
  bit          r_active = 1'b0;
  int          r_cnt = 0;

  // Behavioural model state
  bit          m_busy = 1'b0;
  logic [31:0] m_addr, m_alu;
  logic [1:0]  m_size;
  bit          m_uns, m_store, m_wr;
  logic [4:0]  m_rd;
  logic [31:0] m_req_addr, m_req_wdata;
  logic [3:0]  m_req_wstrb;
  bit          exp_valid = 1'b0;
  logic [4:0]  exp_rd;
  bit          exp_wr, exp_mis;
  logic [31:0] exp_alu, exp_dmr;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteTimeout(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [31:0] fmt_load(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size, input bit uns);
    int unsigned v;
    int unsigned w;
    if (size == 2'd0) begin
      v = (rdata >> (8 * addr[1:0])) & 32'hFF;
      w = 8;
    end else if (size == 2'd1) begin
      v = (rdata >> (16 * addr[1])) & 32'hFFFF;
      w = 16;
    end else begin
      return rdata;
    end
    if (!uns && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  function automatic logic [31:0] store_data(input logic [31:0] data, input logic [1:0] size);
    if (size == 2'd0) return (data & 32'hFF) * 32'h01010101;
    if (size == 2'd1) return (data & 32'hFFFF) * 32'h00010001;
    return data;
  endfunction

  function automatic logic [3:0] store_strobe(input logic [31:0] addr, input logic [1:0] size);
    int unsigned s;
    if (size == 2'd0) s = 1 << addr[1:0];
    else if (size == 2'd1) s = 3 << (2 * addr[1]);
    else s = 15;
    return s[3:0];
  endfunction

  function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] size);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  // Model: decides what the stage must present after each edge
  always @(posedge clk) begin
    bit mem, trap;
    if (rst) begin
      m_busy    = 1'b0;
      exp_valid = 1'b0;
    end else if (!m_busy) begin
      exp_valid = 1'b0;
      if (in_valid) begin
        mem  = in_control_memory_read || in_control_memory_write;
        trap = mem && TRAP_EN && is_misaligned(in_alu_result, in_mem_size);
        if (!mem || trap) begin
          exp_valid = 1'b1;
          exp_rd    = in_destination_register;
          exp_wr    = trap ? 1'b0 : in_control_write_register;
          exp_alu   = in_alu_result;
          exp_dmr   = 32'h0;
          exp_mis   = trap;
        end else begin
          m_busy      = 1'b1;
          m_addr      = in_alu_result;
          m_alu       = in_alu_result;
          m_size      = in_mem_size;
          m_uns       = in_mem_unsigned;
          m_store     = in_control_memory_write;
          m_wr        = in_control_write_register;
          m_rd        = in_destination_register;
          m_req_addr  = in_alu_result - (in_alu_result % 4);
          m_req_wdata = store_data(in_rs2_data, in_mem_size);
          m_req_wstrb = m_store ? store_strobe(in_alu_result, in_mem_size) : 4'h0;
        end
      end
    end else begin
      exp_valid = 1'b0;
      if (dmem_ack) begin
        m_busy    = 1'b0;
        exp_valid = 1'b1;
        exp_rd    = m_rd;
        exp_wr    = m_wr;
        exp_alu   = m_alu;
        exp_dmr   = m_store ? 32'h0 : fmt_load(dmem_rdata, m_addr, m_size, m_uns);
        exp_mis   = 1'b0;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      checkOutput("stall_out", {31'b0, stall_out}, {31'b0, m_busy});
      checkOutput("dmem_req", {31'b0, dmem_req}, {31'b0, m_busy});
      if (m_busy) begin
        checkOutput("dmem_we", {31'b0, dmem_we}, {31'b0, m_store});
        checkOutput("dmem_addr", dmem_addr, m_req_addr);
        checkOutput("dmem_wstrb", {28'b0, dmem_wstrb}, {28'b0, m_req_wstrb});
        if (m_store) checkOutput("dmem_wdata", dmem_wdata, m_req_wdata);
      end
      if (exp_valid) begin
        checkOutput("out_rd", {27'b0, out_destination_register}, {27'b0, exp_rd});
        checkOutput("out_wr", {31'b0, out_control_write_register}, {31'b0, exp_wr});
        checkOutput("out_alu", out_alu_result, exp_alu);
        checkOutput("out_dmr", out_data_memory_result, exp_dmr);
        checkOutput("out_mis", {31'b0, out_misaligned}, {31'b0, exp_mis});
      end
    end
  end

  // Memory responder: acks after a chosen number of extra request cycles
  always @(negedge clk) begin
    if (dmem_req) begin
      if (!r_active) begin
        r_active = 1'b1;
        r_cnt    = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end
      if (r_cnt == 0) begin
        dmem_ack   = 1'b1;
        dmem_rdata = use_fixed_rdata ? fixed_rdata : $urandom;
      end else begin
        dmem_ack   = 1'b0;
        dmem_rdata = $urandom;
        r_cnt--;
      end
    end else begin
      r_active   = 1'b0;
      dmem_ack   = spurious_en && ($urandom_range(0, 3) == 0);
      dmem_rdata = $urandom;
    end
  end

  // Presents a bundle at a negedge and holds it until the stage is not stalling
  task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] data, input logic [4:0] rd,
                               input bit mr, input bit mw, input bit wr,
                               input logic [1:0] size, input bit uns);
    int guard = 0;
    in_alu_result             = alu;
    in_rs2_data               = data;
    in_destination_register   = rd;
    in_control_memory_read    = mr;
    in_control_memory_write   = mw;
    in_control_write_register = wr;
    in_mem_size               = size;
    in_mem_unsigned           = uns;
    in_valid                  = 1'b1;
    while (stall_out && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) noteTimeout("accept");
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitOut(output int req_cycles);
    int guard = 0;
    req_cycles = 0;
    while (!out_valid && guard < 100) begin
      if (dmem_req) req_cycles++;
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) noteTimeout("out_valid");
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    in_alu_result = '0;
    in_rs2_data = '0;
    in_destination_register = '0;
    in_control_memory_read = 1'b0;
    in_control_memory_write = 1'b0;
    in_control_write_register = 1'b0;
    in_mem_size = 2'b00;
    in_mem_unsigned = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("reset_stall", {31'b0, stall_out}, 32'h0);
    checkOutput("reset_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("reset_dmr", out_data_memory_result, 32'h0);
    checkOutput("reset_alu", out_alu_result, 32'h0);
    rst = 1'b0;
    check_en = 1'b1;

    applyStimulus(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0);
    waitOut(n);
    checkOutput("alu_op_latency", n, 0);
    checkOutput("alu_op_result", out_alu_result, 32'h1234);
    checkOutput("alu_op_rd", {27'b0, out_destination_register}, 32'd5);

    fixed_delay = 2;
    use_fixed_rdata = 1'b1;
    fixed_rdata = 32'hDEADBEEF;
    applyStimulus(32'h100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    checkOutput("lw_addr", dmem_addr, 32'h100);
    waitOut(n);
    checkOutput("lw_req_cycles", n, 3);
    checkOutput("lw_data", out_data_memory_result, 32'hDEADBEEF);

    fixed_delay = 0;
    fixed_rdata = 32'h80FF7F01;
    applyStimulus(32'h103, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
    waitOut(n);
    checkOutput("lb_signed", out_data_memory_result, 32'hFFFFFF80);
    applyStimulus(32'h103, 32'h0, 5'd2, 1'b1, 1'b0, 1'b1, 2'd0, 1'b1);
    waitOut(n);
    checkOutput("lbu", out_data_memory_result, 32'h00000080);
    applyStimulus(32'h102, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
    waitOut(n);
    checkOutput("lh_signed", out_data_memory_result, 32'hFFFF80FF);

    fixed_delay = 1;
    applyStimulus(32'h201, 32'h000000AB, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    checkOutput("sb_we", {31'b0, dmem_we}, 32'h1);
    checkOutput("sb_addr", dmem_addr, 32'h200);
    checkOutput("sb_wdata", dmem_wdata, 32'hABABABAB);
    checkOutput("sb_wstrb", {28'b0, dmem_wstrb}, 32'h2);
    waitOut(n);
    checkOutput("sb_dmr", out_data_memory_result, 32'h0);
    applyStimulus(32'h202, 32'h00001234, 5'd0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0);
    checkOutput("sh_wdata", dmem_wdata, 32'h12341234);
    checkOutput("sh_wstrb", {28'b0, dmem_wstrb}, 32'hC);
    waitOut(n);

    fixed_delay = 0;
    applyStimulus(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
`ifdef KAMACORE_MISALIGN_TRAP_EN
    checkOutput("trap_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("trap_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("trap_flag", {31'b0, out_misaligned}, 32'h1);
    checkOutput("trap_wr", {31'b0, out_control_write_register}, 32'h0);
`else
    checkOutput("mis_req", {31'b0, dmem_req}, 32'h1);
    checkOutput("mis_addr", dmem_addr, 32'h100);
    waitOut(n);
`endif

    fixed_delay = 20;
    applyStimulus(32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid_req", {31'b0, dmem_req}, 32'h0);
    checkOutput("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    spurious_en = 1'b1;
    repeat (4) @(negedge clk);
    spurious_en = 1'b0;
    fixed_delay = -1;
    use_fixed_rdata = 1'b0;
    applyStimulus(32'h55, 32'h0, 5'd6, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
    waitOut(n);
    checkOutput("post_rst_alu", out_alu_result, 32'h55);

    spurious_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      applyStimulus($urandom, $urandom, 5'($urandom), kind[0], kind[1], 1'($urandom),
                    2'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) @(negedge clk);
    end
    spurious_en = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
